gtfmac_vnc_second_tick_gen: RTL and testbench
=============================================

GTFMAC_VNC_SECOND_TICK_GEN -- requirements
Module: gtfmac_vnc_second_tick_gen

Interface
REQ-001 The block SHALL have parameter DEFAULT_TICKS, default 32'd100_000_000, giving the interval length in clk cycles loaded at reset.
REQ-002 The block SHALL have parameter MIN_TICKS, default 32'd2, giving the smallest interval length ever used.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is in this domain.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: run interval counting while high.
REQ-006 The block SHALL have port restart, input, 1 bit: single-cycle request to abort the current interval without producing an edge.
REQ-007 The block SHALL have port ticks_per_second, input, 32 bits: requested interval length in clk cycles.
REQ-008 The block SHALL have port one_second_edge, output, 1 bit: registered level that toggles once per completed interval, for consumption by edge-detecting counters in other clock domains.
REQ-009 The block SHALL have port one_second_pulse, output, 1 bit: registered one-cycle strobe per completed interval.
REQ-010 The block SHALL have port seconds_count, output, 32 bits: number of completed intervals.
REQ-011 The block SHALL have port ticks_active, output, 32 bits: interval length currently in force.

Function
REQ-012 The block SHALL hold an internal 32-bit cycle counter cnt and a 32-bit shadow period P, where P drives ticks_active.
REQ-013 The block SHALL form the effective load value as max(ticks_per_second, MIN_TICKS).
REQ-014 While enable=0, the block SHALL hold cnt=0, hold one_second_edge, hold seconds_count, drive one_second_pulse=0, and load P from the effective load value every cycle.
REQ-015 While enable=1 and restart=0, if cnt < P-1 the block SHALL increment cnt by 1.
REQ-016 While enable=1 and restart=0, if cnt = P-1 (the terminal cycle), on the next clk edge the block SHALL:
  - set cnt=0;
  - invert one_second_edge;
  - set one_second_pulse=1;
  - increment seconds_count modulo 2^32, so 0xFFFFFFFF wraps to 0;
  - load P from the effective load value.
REQ-017 The block SHALL drive one_second_pulse=0 on every cycle not described in REQ-016.
REQ-018 The block SHALL sample ticks_per_second only on terminal cycles, while enable=0, and on restart, so changes mid-interval never shorten or stretch the running interval.
REQ-019 When restart=1 and enable=1, the block SHALL set cnt=0, load P, hold one_second_edge and seconds_count, and drive one_second_pulse=0.
REQ-020 When restart=1 coincides with a terminal cycle, restart SHALL win and no edge, pulse or count increment SHALL occur.
REQ-021 When restart=1 and enable=0, the block SHALL behave as enable=0.
REQ-022 When enable rises, the first edge SHALL occur exactly P clk cycles after the first cycle on which enable is sampled high.
REQ-023 In steady state one_second_edge SHALL toggle exactly every P cycles, and consecutive toggles SHALL be at least MIN_TICKS cycles apart.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-025 On assertion of reset (low), the block SHALL asynchronously set cnt=0, one_second_edge=0, one_second_pulse=0, seconds_count=0 and P=max(DEFAULT_TICKS, MIN_TICKS).
REQ-026 The block SHALL release reset synchronously to clk, and the first post-reset interval SHALL begin on the first clk edge after release with enable=1.
REQ-027 If reset asserts mid-interval, the partial interval SHALL be discarded and no edge or pulse SHALL be produced.

Verification
REQ-028 With DEFAULT_TICKS=10, enable=1 and ticks_per_second=10 held for 35 cycles after reset, the bench SHALL see toggles at cycles 10, 20 and 30, pulses on the same cycles, and seconds_count=3.
REQ-029 With P=10, changing ticks_per_second to 4 at cnt=3, the bench SHALL see the current interval still end at cnt=9, after which edges occur every 4 cycles and ticks_active=4.
REQ-030 With ticks_per_second=0 or 1, the bench SHALL see ticks_active=2 and one_second_edge toggle every 2 cycles with no back-to-back toggles.
REQ-031 With restart asserted exactly on a terminal cycle, the bench SHALL see no toggle, no pulse and seconds_count unchanged, with the next edge arriving P cycles later.
REQ-032 With seconds_count preset to 0xFFFFFFFF (by force) followed by one completed interval, the bench SHALL see seconds_count=0 and the edge toggle.
REQ-033 With enable dropped for 7 cycles then raised, and reset pulsed low mid-interval, the bench SHALL see outputs frozen while enable=0, the first edge P cycles after re-enable, and all outputs at reset values immediately on reset assertion.

Source files
------------

// File: rtl/gtfmac_vnc_second_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : gtfmac_vnc_second_tick_gen
// Purpose  : Programmable interval ("one second") tick generator. Produces a
//            toggling level and a one-cycle strobe per completed interval,
//            counts completed intervals and reports the period in force.
//            New periods take effect only at interval boundaries, so a
//            mid-interval reprogram never distorts the running interval.
// Revision : 1.0 - initial release
// ============================================================================
module gtfmac_vnc_second_tick_gen #(
  parameter logic [31:0] DEFAULT_TICKS = 32'd100_000_000,
  parameter logic [31:0] MIN_TICKS     = 32'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        restart,
  input  logic [31:0] ticks_per_second,
  output logic        one_second_edge,
  output logic        one_second_pulse,
  output logic [31:0] seconds_count,
  output logic [31:0] ticks_active
);

  // Period loaded at reset, clamped so the interval is never shorter than MIN_TICKS.
  localparam logic [31:0] c_reset_period =
    (DEFAULT_TICKS < MIN_TICKS) ? MIN_TICKS : DEFAULT_TICKS;

  logic [31:0] r_cnt;
  logic [31:0] r_period;
  logic        r_edge;
  logic        r_pulse;
  logic [31:0] r_seconds_count;

  logic [31:0] w_load;
  logic        w_terminal;

  // Requested period clamped to the minimum; only sampled at boundaries.
  assign w_load     = (ticks_per_second < MIN_TICKS) ? MIN_TICKS : ticks_per_second;
  // Last cycle of the running interval.
  assign w_terminal = (r_cnt == (r_period - 32'd1));

  // Interval counter, shadow period and tick outputs; restart beats terminal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt           <= '0;
      r_period        <= c_reset_period;
      r_edge          <= 1'b0;
      r_pulse         <= 1'b0;
      r_seconds_count <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (!enable || restart) begin
        r_cnt    <= '0;
        r_period <= w_load;
      end else if (w_terminal) begin
        r_cnt           <= '0;
        r_period        <= w_load;
        r_edge          <= ~r_edge;
        r_pulse         <= 1'b1;
        r_seconds_count <= r_seconds_count + 32'd1;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign one_second_edge  = r_edge;
  assign one_second_pulse = r_pulse;
  assign seconds_count    = r_seconds_count;
  assign ticks_active     = r_period;

endmodule
`default_nettype wire

// File: tb/tb_gtfmac_vnc_second_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_gtfmac_vnc_second_tick_gen
// Purpose  : Self-checking bench for gtfmac_vnc_second_tick_gen. A timestamp
//            model predicts outputs every cycle; directed scenarios add
//            hand-computed expectations for pulse positions and counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gtfmac_vnc_second_tick_gen;

  localparam logic [31:0] c_default = 32'd10;
  localparam logic [31:0] c_min     = 32'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        restart = 1'b0;
  logic [31:0] ticks_per_second = 32'd10;
  logic        one_second_edge;
  logic        one_second_pulse;
  logic [31:0] seconds_count;
  logic [31:0] ticks_active;

  int n_checks = 0;
  int n_fail   = 0;

  gtfmac_vnc_second_tick_gen #(
    .DEFAULT_TICKS (c_default),
    .MIN_TICKS     (c_min)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .restart          (restart),
    .ticks_per_second (ticks_per_second),
    .one_second_edge  (one_second_edge),
    .one_second_pulse (one_second_pulse),
    .seconds_count    (seconds_count),
    .ticks_active     (ticks_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: interval = last boundary edge + period ----------
  int          n = 0;            // clock edges completed so far
  int          m_last = 0;       // edge index of the most recent boundary
  logic [31:0] m_p = c_default;
  logic        m_edge = 1'b0;
  logic        m_pulse = 1'b0;
  logic [31:0] m_sec = '0;

  function automatic logic [31:0] eff(input logic [31:0] t);
    return (t < c_min) ? c_min : t;
  endfunction

  always @(posedge clk) n <= n + 1;

  always @(negedge reset) begin
    m_edge = 1'b0; m_pulse = 1'b0; m_sec = '0; m_p = c_default; m_last = n;
  end

  always @(posedge clk) begin
    int cur;
    cur = n + 1;
    if (!reset) begin
      m_edge = 1'b0; m_pulse = 1'b0; m_sec = '0; m_p = c_default; m_last = cur;
    end else begin
      m_pulse = 1'b0;
      if (!enable || restart) begin
        m_p = eff(ticks_per_second);
        m_last = cur;
      end else if ((cur - m_last) == int'(m_p)) begin
        m_edge  = ~m_edge;
        m_pulse = 1'b1;
        m_sec   = m_sec + 32'd1;
        m_p     = eff(ticks_per_second);
        m_last  = cur;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_edge",  {31'd0, one_second_edge},  {31'd0, m_edge});
    chk("cmp_pulse", {31'd0, one_second_pulse}, {31'd0, m_pulse});
    chk("cmp_count", seconds_count, m_sec);
    chk("cmp_ticks", ticks_active, m_p);
  end

  // ---------------- directed helpers ---------------------------------------
  int pulses[$];
  int rel = 0;

  task automatic begin_rec();
    pulses.delete();
    rel = 0;
  endtask

  task automatic run_edges(input int num);
    for (int i = 0; i < num; i++) begin
      @(negedge clk);
      rel++;
      if (one_second_pulse) pulses.push_back(rel);
    end
  endtask

  task automatic chk_q(input string name, input int exp[$]);
    bit    ok;
    string sa;
    string se;
    n_checks++;
    ok = (pulses.size() == exp.size());
    if (ok) foreach (exp[i]) if (pulses[i] != exp[i]) ok = 1'b0;
    if (!ok) begin
      n_fail++;
      sa = ""; se = "";
      foreach (pulses[i]) sa = {sa, $sformatf("%0d ", pulses[i])};
      foreach (exp[i]) se = {se, $sformatf("%0d ", exp[i])};
      $display("FAIL %s: pulse cycles got { %s} expected { %s}", name, sa, se);
    end
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_edge",  {31'd0, one_second_edge}, 32'd0);
    chk("rst_count", seconds_count, 32'd0);
    chk("rst_ticks", ticks_active, 32'd10);
    reset = 1'b1;

    // Steady 10-cycle intervals after reset release.
    begin_rec();
    run_edges(35);
    chk_q("basic_pulses", '{10, 20, 30});
    chk("basic_count", seconds_count, 32'd3);
    chk("basic_edge", {31'd0, one_second_edge}, 32'd1);

    // Reprogram to 4 mid-interval (cnt=3): running interval unaffected.
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    begin_rec();
    run_edges(3);
    ticks_per_second = 32'd4;
    run_edges(3);
    chk("reprog_ticks_mid", ticks_active, 32'd10);
    run_edges(13);
    chk_q("reprog_pulses", '{10, 14, 18});
    chk("reprog_ticks", ticks_active, 32'd4);
    chk("reprog_count", seconds_count, 32'd6);

    // Requests below the minimum clamp to 2.
    ticks_per_second = 32'd0;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    begin_rec();
    run_edges(8);
    chk_q("min0_pulses", '{2, 4, 6, 8});
    chk("min0_ticks", ticks_active, 32'd2);
    ticks_per_second = 32'd1;
    run_edges(4);
    chk_q("min1_pulses", '{2, 4, 6, 8, 10, 12});
    chk("min1_ticks", ticks_active, 32'd2);
    chk("min_count", seconds_count, 32'd12);

    // Restart on the terminal cycle suppresses the tick.
    ticks_per_second = 32'd5;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    begin_rec();
    run_edges(4);
    restart = 1'b1;
    run_edges(1);
    restart = 1'b0;
    chk("restart_count_held", seconds_count, 32'd12);
    run_edges(5);
    chk_q("restart_pulses", '{10});
    chk("restart_count", seconds_count, 32'd13);
    chk("restart_edge", {31'd0, one_second_edge}, 32'd1);

    // Counter wrap from all-ones.
    enable = 1'b0;
    @(negedge clk);
    #1;
    force dut.r_seconds_count = 32'hFFFF_FFFF;
    m_sec = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    release dut.r_seconds_count;
    @(negedge clk);
    chk("wrap_preset", seconds_count, 32'hFFFF_FFFF);
    enable = 1'b1;
    begin_rec();
    run_edges(5);
    chk_q("wrap_pulses", '{5});
    chk("wrap_count", seconds_count, 32'd0);
    chk("wrap_edge", {31'd0, one_second_edge}, 32'd0);

    // Disable for 7 cycles mid-interval, then re-enable.
    ticks_per_second = 32'd6;
    run_edges(2);
    enable = 1'b0;
    begin_rec();
    run_edges(7);
    chk_q("dis_pulses", '{});
    chk("dis_edge", {31'd0, one_second_edge}, 32'd0);
    chk("dis_count", seconds_count, 32'd0);
    chk("dis_ticks", ticks_active, 32'd6);
    enable = 1'b1;
    begin_rec();
    run_edges(8);
    chk_q("reen_pulses", '{6});
    chk("reen_count", seconds_count, 32'd1);

    // Asynchronous reset mid-interval.
    #2;
    reset = 1'b0;
    #1;
    chk("arst_edge",  {31'd0, one_second_edge}, 32'd0);
    chk("arst_pulse", {31'd0, one_second_pulse}, 32'd0);
    chk("arst_count", seconds_count, 32'd0);
    chk("arst_ticks", ticks_active, 32'd10);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ticks_per_second = 32'd10;
    begin_rec();
    run_edges(11);
    chk_q("post_rst_pulses", '{10});
    chk("post_rst_count", seconds_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
